// File: rtl/ps2_kbd_rx.sv
// PS/2 device-to-host receiver: synchronise, glitch-filter, deframe 11-bit odd-parity frames.
// Optional frame watchdog enabled by defining PS2_KBD_RX_TIMEOUT_EN.
module ps2_kbd_rx #(
  parameter int FREQ_HZ    = 1000000,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] code_o,
  output logic       strobe_o,
  output logic       err_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int         TIMEOUT_CYC = FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam logic [3:0] FILT_LAST   = 4'(FILTER_LEN - 1);

  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
    $error("ps2_kbd_rx: FILTER_LEN must be in 1..15");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("ps2_kbd_rx: timeout must be at least 2 cycles");
  end

  logic       clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic       data_s1_q, data_s1_d, data_s2_q, data_s2_d;
  logic [3:0] clk_run_q, clk_run_d, data_run_q, data_run_d;
  logic       clk_filt_q, clk_filt_d, data_filt_q, data_filt_d;
  logic       clk_prev_q, clk_prev_d;
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, code_q, code_d;
  logic       parity_q, parity_d;
  logic       strobe_q, strobe_d, err_q, err_d, busy_q, busy_d;
  logic       edge_evt;

`ifdef PS2_KBD_RX_TIMEOUT_EN
  localparam int             WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  assign edge_evt = clk_prev_q & ~clk_filt_q;

  always_comb begin
    clk_s1_d   = ps2_clk_i;
    clk_s2_d   = clk_s1_q;
    data_s1_d  = ps2_data_i;
    data_s2_d  = data_s1_q;
    clk_prev_d = clk_filt_q;

    // A level change is accepted only after FILTER_LEN consecutive opposite samples.
    clk_filt_d = clk_filt_q;
    clk_run_d  = '0;
    if (clk_s2_q != clk_filt_q) begin
      if (clk_run_q == FILT_LAST) clk_filt_d = clk_s2_q;
      else                        clk_run_d  = clk_run_q + 4'd1;
    end
    data_filt_d = data_filt_q;
    data_run_d  = '0;
    if (data_s2_q != data_filt_q) begin
      if (data_run_q == FILT_LAST) data_filt_d = data_s2_q;
      else                         data_run_d  = data_run_q + 4'd1;
    end

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    code_d    = code_q;
    strobe_d  = 1'b0;
    err_d     = 1'b0;
    if (edge_evt) begin
      case (state_q)
        IDLE: begin
          if (!data_filt_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d[bit_cnt_q] = data_filt_q;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = data_filt_q;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if ((^{shift_q, parity_q}) && data_filt_q) begin
            code_d   = shift_q;
            strobe_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef PS2_KBD_RX_TIMEOUT_EN
    // Edge events always win over an expiring watchdog.
    wd_d = '0;
    if (state_q != IDLE && !edge_evt) begin
      if (wd_q == WD_LAST) begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        shift_d   = '0;
        err_d     = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      data_s1_q   <= 1'b1;
      data_s2_q   <= 1'b1;
      clk_run_q   <= '0;
      data_run_q  <= '0;
      clk_filt_q  <= 1'b1;
      data_filt_q <= 1'b1;
      clk_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      code_q      <= '0;
      strobe_q    <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PS2_KBD_RX_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      data_s1_q   <= data_s1_d;
      data_s2_q   <= data_s2_d;
      clk_run_q   <= clk_run_d;
      data_run_q  <= data_run_d;
      clk_filt_q  <= clk_filt_d;
      data_filt_q <= data_filt_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      code_q      <= code_d;
      strobe_q    <= strobe_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
`ifdef PS2_KBD_RX_TIMEOUT_EN
      wd_q        <= wd_d;
`endif
    end
  end

  assign code_o   = code_q;
  assign strobe_o = strobe_q;
  assign err_o    = err_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed self-checking bench for ps2_kbd_rx (1 MHz system clock, 12.5 kHz PS/2 clock).
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

  logic       clk;
  logic       reset_i;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic [7:0] code_o;
  logic       strobe_o;
  logic       err_o;
  logic       busy_o;

  int errors = 0;
  int checks = 0;

  int cycle_cnt = 0;
  int fall_cyc = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int both_cnt = 0;
  int wide_cnt = 0;
  logic busy_at_strobe = 1'b0;
  logic busy_at_err = 1'b0;
  logic strobe_prev = 1'b0;
  logic err_prev = 1'b0;

  ps2_kbd_rx #(
    .FREQ_HZ   (1000000),
    .FILTER_LEN(4),
    .TIMEOUT_US(2000)
  ) dut (
    .clk       (clk),
    .reset_i   (reset_i),
    .ps2_clk_i (ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .code_o    (code_o),
    .strobe_o  (strobe_o),
    .err_o     (err_o),
    .busy_o    (busy_o)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Pulse monitor, sampled on the falling system clock edge.
  always @(negedge clk) begin
    if (strobe_o === 1'b1) begin
      strobe_cnt++;
      busy_at_strobe = busy_o;
    end
    if (err_o === 1'b1) begin
      err_cnt++;
      err_cyc = cycle_cnt;
      busy_at_err = busy_o;
    end
    if (strobe_o === 1'b1 && err_o === 1'b1) both_cnt++;
    if ((strobe_o === 1'b1 && strobe_prev === 1'b1) || (err_o === 1'b1 && err_prev === 1'b1))
      wide_cnt++;
    strobe_prev = strobe_o;
    err_prev = err_o;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Device-side frame: data changes mid-high, 40-cycle low, 20-cycle high.
  // Sends the first nbits of {stop, parity, data, start}; glitch_after inserts a 2-cycle clock glitch.
  task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop,
                               input int nbits, input int glitch_after);
    logic [10:0] frame;
    frame = {stop, par, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data_i = frame[i];
      waitCycles(20);
      ps2_clk_i = 1'b0;
      fall_cyc = cycle_cnt;
      waitCycles(40);
      ps2_clk_i = 1'b1;
      waitCycles(20);
      if (i == glitch_after) begin
        ps2_clk_i = 1'b0;
        waitCycles(2);
        ps2_clk_i = 1'b1;
        waitCycles(20);
      end
    end
    ps2_data_i = 1'b1;
    waitCycles(10);
  endtask

  task automatic pulseReset();
    reset_i = 1'b1;
    waitCycles(1);
    reset_i = 1'b0;
  endtask

  initial begin
    int s0, e0, idle_seen;
    reset_i = 1'b1;
    ps2_clk_i = 1'b1;
    ps2_data_i = 1'b1;
    waitCycles(3);
    reset_i = 1'b0;

    checkOutput("reset_code", code_o, 8'h00);
    checkOutput("reset_strobe", strobe_o, 1'b0);
    checkOutput("reset_err", err_o, 1'b0);
    checkOutput("reset_busy", busy_o, 1'b0);
    waitCycles(20);

    // Single frame 0x1C, parity 0.
    s0 = strobe_cnt; e0 = err_cnt;
    applyStimulus(8'h1C, 1'b0, 1'b1, 11, -1);
    checkOutput("f1c_strobes", strobe_cnt - s0, 1);
    checkOutput("f1c_errs", err_cnt - e0, 0);
    checkOutput("f1c_code", code_o, 8'h1C);
    checkOutput("f1c_busy_after", busy_o, 1'b0);
    checkOutput("f1c_busy_at_strobe", busy_at_strobe, 1'b0);

    // Back-to-back 0xF0 then 0x1C.
    s0 = strobe_cnt;
    applyStimulus(8'hF0, 1'b1, 1'b1, 11, -1);
    checkOutput("b2b_first_code", code_o, 8'hF0);
    applyStimulus(8'h1C, 1'b0, 1'b1, 11, -1);
    checkOutput("b2b_second_code", code_o, 8'h1C);
    checkOutput("b2b_strobes", strobe_cnt - s0, 2);

    // Bad parity, then bad stop bit: code must keep 0xF0.
    applyStimulus(8'hF0, 1'b1, 1'b1, 11, -1);
    s0 = strobe_cnt; e0 = err_cnt;
    applyStimulus(8'h1C, 1'b1, 1'b1, 11, -1);
    checkOutput("badpar_errs", err_cnt - e0, 1);
    checkOutput("badpar_strobes", strobe_cnt - s0, 0);
    checkOutput("badpar_code", code_o, 8'hF0);
    checkOutput("badpar_busy", busy_o, 1'b0);
    checkOutput("badpar_busy_at_err", busy_at_err, 1'b0);
    e0 = err_cnt;
    applyStimulus(8'h1C, 1'b0, 1'b0, 11, -1);
    waitCycles(20);
    checkOutput("badstop_errs", err_cnt - e0, 1);
    checkOutput("badstop_code", code_o, 8'hF0);

    // Glitches in idle and mid-frame must be ignored.
    s0 = strobe_cnt; e0 = err_cnt;
    ps2_clk_i = 1'b0;
    waitCycles(2);
    ps2_clk_i = 1'b1;
    waitCycles(20);
    checkOutput("idle_glitch_busy", busy_o, 1'b0);
    applyStimulus(8'h5A, 1'b1, 1'b1, 11, 3);
    checkOutput("glitch_strobes", strobe_cnt - s0, 1);
    checkOutput("glitch_errs", err_cnt - e0, 0);
    checkOutput("glitch_code", code_o, 8'h5A);

    // Reset after start plus 4 data bits.
    e0 = err_cnt;
    applyStimulus(8'h1C, 1'b0, 1'b1, 5, -1);
    checkOutput("midreset_busy_before", busy_o, 1'b1);
    pulseReset();
    checkOutput("midreset_busy", busy_o, 1'b0);
    checkOutput("midreset_code", code_o, 8'h00);
    waitCycles(20);
    checkOutput("midreset_errs", err_cnt - e0, 0);
    s0 = strobe_cnt;
    applyStimulus(8'h1C, 1'b0, 1'b1, 11, -1);
    checkOutput("postreset_strobes", strobe_cnt - s0, 1);
    checkOutput("postreset_code", code_o, 8'h1C);

    // Stall after start plus 3 data bits for 3000 cycles.
    e0 = err_cnt;
    idle_seen = 0;
    applyStimulus(8'h1C, 1'b0, 1'b1, 4, -1);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (busy_o !== 1'b1) idle_seen++;
    end
`ifdef PS2_KBD_RX_TIMEOUT_EN
    checkOutput("timeout_errs", err_cnt - e0, 1);
    checkOutput("timeout_latency_ok",
                ((err_cyc - fall_cyc) >= 2004 && (err_cyc - fall_cyc) <= 2010), 1'b1);
    checkOutput("timeout_busy_at_err", busy_at_err, 1'b0);
    checkOutput("timeout_busy_after", busy_o, 1'b0);
    checkOutput("timeout_code_held", code_o, 8'h1C);
`else
    checkOutput("stall_errs", err_cnt - e0, 0);
    checkOutput("stall_busy_low_cycles", idle_seen, 0);
    pulseReset();
    checkOutput("stall_reset_busy", busy_o, 1'b0);
`endif
    s0 = strobe_cnt;
    applyStimulus(8'h1C, 1'b0, 1'b1, 11, -1);
    checkOutput("afterstall_strobes", strobe_cnt - s0, 1);
    checkOutput("afterstall_code", code_o, 8'h1C);

    checkOutput("never_both_pulses", both_cnt, 0);
    checkOutput("pulses_single_cycle", wide_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
